// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the streaming median filter: reads one frame from a
// synchronous-read source memory, streams it into the filter one pixel per
// clock, and writes the aligned filter outputs to a destination memory.
module median_frame_ctrl #(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int OUT_OFFSET = 2*WIDTH+2,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        filt_pixel_in,
    input  logic [7:0]        filt_pixel_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_border,
    output logic [31:0]       cycle_count
);

    localparam int N     = WIDTH * HEIGHT;
    // Two spare bits so the run counter can reach N+1 without wrapping.
    localparam int CW    = ADDR_W + 2;
    localparam int COL_W = $clog2(WIDTH);

    localparam logic [CW-1:0]    RD_END     = CW'(N);
    localparam logic [CW-1:0]    LAST_CYC   = CW'(N + 1);
    localparam logic [CW-1:0]    PIX_FIRST  = CW'(1);
    // Pixel j reaches the filter in cycle j+2, so output m is due in cycle m+OUT_OFFSET+2.
    localparam logic [CW-1:0]    WR_FIRST   = CW'(OUT_OFFSET + 2);
    localparam logic [COL_W-1:0] COL_MAX    = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_BORDER = COL_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cyc;
    logic [COL_W-1:0]  col;
    logic              load_pixel;
    logic              last_run;
    logic [63:0]       run_total;

    assign last_run   = (state == RUN) && !abort && (cyc == LAST_CYC);
    assign run_total  = 64'(cyc) + 64'd1;
    // rd_data in cycle c holds source pixel c-1; register it into the filter for c = 1..N.
    assign load_pixel = (state == RUN) && !abort && (cyc >= PIX_FIRST) && (cyc <= RD_END);

    // State register.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and combinational outputs derived from state and run counter.
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_border  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cyc < RD_END) begin
                    rd_en   = 1'b1;
                    rd_addr = cyc[ADDR_W-1:0];
                end
                if (cyc >= WR_FIRST) begin
                    wr_en     = 1'b1;
                    wr_addr   = ADDR_W'(cyc - WR_FIRST);
                    wr_data   = filt_pixel_out;
                    wr_border = (col >= COL_BORDER);
                end
                if (abort)                 state_next = IDLE;
                else if (cyc == LAST_CYC)  state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run cycle counter and output column counter; both restart outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= '0;
            col <= '0;
        end else if (state != RUN) begin
            cyc <= '0;
            col <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (wr_en) col <= (col == COL_MAX) ? '0 : col + 1'b1;
        end
    end

    // Filter input register: carries source pixels during the stream, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             filt_pixel_in <= 8'h00;
        else if (load_pixel) filt_pixel_in <= rd_data;
        else                 filt_pixel_in <= 8'h00;
    end

    // Latch the busy-cycle total, saturating, when a frame completes normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (last_run) begin
            cycle_count <= (run_total > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : run_total[31:0];
        end
    end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Self-checking bench for median_frame_ctrl on a 4x4 frame with a
// delay-line stand-in for the median filter (output = input 10 cycles ago).
module tb_median_frame_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int OFF = 10;
    localparam int AW  = 8;
    localparam int N   = W * H;
    localparam int DLY = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic [7:0]    filt_pixel_in;
    logic [7:0]    filt_pixel_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_border;
    logic [31:0]   cycle_count;

    logic [7:0]    src [N];
    logic [7:0]    dly [DLY] = '{default: 8'h00};

    int            n_cmp  = 0;
    int            n_err  = 0;
    logic [31:0]   exp_cc = 32'd0;

    median_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .OUT_OFFSET(OFF), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .filt_pixel_in(filt_pixel_in), .filt_pixel_out(filt_pixel_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_border(wr_border), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read source memory.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < N) rd_data <= src[rd_addr];
    end

    // Filter stand-in: pure delay of DLY cycles.
    always @(posedge clk) begin
        dly[0] <= filt_pixel_in;
        for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
    end
    assign filt_pixel_out = dly[DLY-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_src(input bit random);
        for (int k = 0; k < N; k++) src[k] = random ? 8'($urandom) : 8'(k);
    endtask

    // Pulse start for one cycle; returns at the sample point of run cycle 0.
    task automatic launch();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, rd_en, wr_en, wr_border, rd_addr, wr_addr, wr_data, filt_pixel_in, cycle_count} !== '0) begin
            n_err++;
            $display("FAIL reset_hold got busy=%b done=%b rd_en=%b wr_en=%b fpi=%h cc=%0d required all zero",
                     busy, done, rd_en, wr_en, filt_pixel_in, cycle_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        next_cycle();
        n_cmp++;
        if ({busy, done, rd_en, wr_en, wr_border, rd_addr, wr_addr, wr_data, filt_pixel_in, cycle_count} !== '0) begin
            n_err++;
            $display("FAIL reset_release got busy=%b done=%b rd_en=%b wr_en=%b fpi=%h cc=%0d required all zero",
                     busy, done, rd_en, wr_en, filt_pixel_in, cycle_count);
        end
        exp_cc = 32'd0;
    endtask

    // Full frame checked cycle by cycle against the timing rules of the sequencer.
    task automatic test_frame(input bit random);
        logic       e_busy, e_done, e_rd, e_wr, e_bord;
        logic [7:0] e_pin;
        int         m;
        int         writes;
        fill_src(random);
        writes = 0;
        launch();
        for (int c = 0; c <= N + 4; c++) begin
            e_busy = (c <= N + 1);
            e_done = (c == N + 2);
            e_rd   = (c < N);
            e_wr   = (c >= OFF + 2) && (c <= N + 1);
            e_pin  = 8'h00;
            if (c >= 2 && c <= N + 1) e_pin = src[c-2];
            n_cmp++;
            if ({busy, done, rd_en, wr_en} !== {e_busy, e_done, e_rd, e_wr}) begin
                n_err++;
                $display("FAIL frame_ctrl c=%0d got busy,done,rd_en,wr_en=%b%b%b%b required %b%b%b%b",
                         c, busy, done, rd_en, wr_en, e_busy, e_done, e_rd, e_wr);
            end
            if (e_rd) begin
                n_cmp++;
                if (rd_addr !== 8'(c)) begin
                    n_err++;
                    $display("FAIL frame_rd_addr c=%0d got %0d required %0d", c, rd_addr, c);
                end
            end
            n_cmp++;
            if (filt_pixel_in !== e_pin) begin
                n_err++;
                $display("FAIL frame_pixel_in c=%0d got %h required %h", c, filt_pixel_in, e_pin);
            end
            if (e_wr) begin
                m      = c - 2 - OFF;
                e_bord = (m % W) >= (W - 2);
                writes++;
                n_cmp++;
                if ({wr_addr, wr_data, wr_border} !== {8'(m), src[m], e_bord}) begin
                    n_err++;
                    $display("FAIL frame_write c=%0d got addr=%0d data=%h border=%b required addr=%0d data=%h border=%b",
                             c, wr_addr, wr_data, wr_border, m, src[m], e_bord);
                end
            end
            next_cycle();
        end
        exp_cc = 32'(N + 2);
        n_cmp++;
        if (cycle_count !== exp_cc) begin
            n_err++;
            $display("FAIL frame_cycle_count got %0d required %0d", cycle_count, exp_cc);
        end
        n_cmp++;
        if (writes != N - OFF) begin
            n_err++;
            $display("FAIL frame_write_count got %0d required %0d", writes, N - OFF);
        end
    endtask

    // Abort during RUN at cycle 'at': idle from the next edge, no done, count kept.
    task automatic test_abort(input int at);
        int bad;
        fill_src(1'b1);
        launch();
        for (int c = 0; c < at; c++) next_cycle();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre at=%0d got busy=%b required 1", at, busy);
        end
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        for (int k = 0; k < 2 * DLY; k++) begin
            bad = 0;
            if ({busy, rd_en, wr_en, done} !== 4'b0000) bad = 1;
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL abort_idle at=%0d k=%0d got busy,rd_en,wr_en,done=%b%b%b%b required 0000",
                         at, k, busy, rd_en, wr_en, done);
            end
            next_cycle();
        end
        n_cmp++;
        if (cycle_count !== exp_cc) begin
            n_err++;
            $display("FAIL abort_cycle_count at=%0d got %0d required %0d", at, cycle_count, exp_cc);
        end
    endtask

    // Starts in RUN/DONE and start+abort in IDLE are all ignored.
    task automatic test_ignored_start();
        int busy_n, done_n, wr_n, stray;
        busy_n = 0; done_n = 0; wr_n = 0; stray = 0;
        fill_src(1'b1);
        launch();
        for (int c = 0; c <= N + 8; c++) begin
            start = (c == 3) || (c == N + 1) || (c == N + 2);
            busy_n += int'(busy);
            done_n += int'(done);
            wr_n   += int'(wr_en);
            next_cycle();
        end
        start = 1'b0;
        n_cmp++;
        if (busy_n != N + 2 || done_n != 1 || wr_n != N - OFF) begin
            n_err++;
            $display("FAIL ignored_start got busy=%0d done=%0d writes=%0d required %0d/1/%0d",
                     busy_n, done_n, wr_n, N + 2, N - OFF);
        end
        start = 1'b1; abort = 1'b1;
        next_cycle();
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            stray += int'(busy) + int'(rd_en);
            next_cycle();
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL start_with_abort got %0d busy/rd cycles required 0", stray);
        end
        n_cmp++;
        if (cycle_count !== exp_cc) begin
            n_err++;
            $display("FAIL ignored_cycle_count got %0d required %0d", cycle_count, exp_cc);
        end
    endtask

    // Start in the cycle right after done; abort during DONE is harmless.
    task automatic test_back_to_back();
        int done_at;
        fill_src(1'b1);
        launch();
        for (int c = 0; c < N + 2; c++) next_cycle();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first_done got %b required 1", done);
        end
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_gap got busy,done=%b%b required 00", busy, done);
        end
        launch();
        n_cmp++;
        if ({busy, rd_en, rd_addr} !== {1'b1, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL b2b_accept got busy=%b rd_en=%b rd_addr=%0d required 1/1/0", busy, rd_en, rd_addr);
        end
        done_at = -1;
        for (int c = 0; c < N + 10 && done_at < 0; c++) begin
            if (done === 1'b1) done_at = c;
            next_cycle();
        end
        n_cmp++;
        if (done_at != N + 2) begin
            n_err++;
            $display("FAIL b2b_second_done got cycle %0d required %0d (-1 means timeout)", done_at, N + 2);
        end
        exp_cc = 32'(N + 2);
        n_cmp++;
        if (cycle_count !== exp_cc) begin
            n_err++;
            $display("FAIL b2b_cycle_count got %0d required %0d", cycle_count, exp_cc);
        end
    endtask

    // Reset asserted between edges while writing: outputs drop at once, no later writes.
    task automatic test_async_reset();
        int stray;
        stray = 0;
        fill_src(1'b1);
        launch();
        for (int c = 0; c < 12; c++) next_cycle();
        n_cmp++;
        if (wr_en !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre got wr_en=%b required 1", wr_en);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, rd_en, wr_en, wr_border, rd_addr, wr_addr, wr_data, filt_pixel_in, cycle_count} !== '0) begin
            n_err++;
            $display("FAIL areset_now got busy=%b rd_en=%b wr_en=%b wr_data=%h fpi=%h cc=%0d required all zero",
                     busy, rd_en, wr_en, wr_data, filt_pixel_in, cycle_count);
        end
        exp_cc = 32'd0;
        #2 rst = 1'b0;
        for (int k = 0; k < N + 6; k++) begin
            next_cycle();
            stray += int'(busy) + int'(wr_en) + int'(done);
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL areset_after got %0d active cycles required 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_abort(8);
        test_frame(1'b0);
        test_abort(N + 1);
        test_abort(int'($urandom_range(0, N + 1)));
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        test_frame(1'b1);
        test_frame(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
